// File: rtl/cx_hart_arbiter_pkg.sv
// Shared CX field widths and arbiter types: tag table entry, held response, grant FSM states.
package cxu_types;

    localparam int unsigned C_M_CXU_CXU_ID_W   = 4;
    localparam int unsigned C_M_CXU_STATE_ID_W = 4;
    localparam int unsigned C_M_CXU_INSN_W     = 32;
    localparam int unsigned C_M_CXU_FUNC_ID_W  = 10;
    localparam int unsigned C_M_CXU_DATA_W     = 32;
    localparam int unsigned C_M_CXU_REQ_ID_W   = 6;
    localparam int unsigned C_M_CXU_STATUS_W   = 2;

    // Downstream tags travel in the req_id field; owner index supports up to 16 requesters.
    localparam int unsigned CX_ARB_TAG_W   = C_M_CXU_REQ_ID_W;
    localparam int unsigned CX_ARB_OWNER_W = 4;

    typedef struct packed {
        logic [CX_ARB_OWNER_W-1:0]   owner;
        logic [C_M_CXU_REQ_ID_W-1:0] orig_id;
    } cx_arb_tag_entry_t;

    typedef struct packed {
        logic [C_M_CXU_DATA_W-1:0]   data;
        logic [C_M_CXU_REQ_ID_W-1:0] id;
        logic [C_M_CXU_STATUS_W-1:0] status;
    } cx_arb_resp_t;

    typedef enum logic {
        CX_ARB_IDLE   = 1'b0,
        CX_ARB_LOCKED = 1'b1
    } cx_arb_state_e;

endpackage

// File: rtl/cx_hart_arbiter_if.sv
// Bundled requester-side (s_*) and downstream (m_*) CX channels; slave = arbiter view, master = environment view.
interface cx_hart_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    import cxu_types::*;

    logic [NUM_REQ-1:0]                    s_req_valid;
    logic [NUM_REQ-1:0]                    s_req_ready;
    logic [NUM_REQ*C_M_CXU_CXU_ID_W-1:0]   s_req_cxu;
    logic [NUM_REQ*C_M_CXU_STATE_ID_W-1:0] s_req_state;
    logic [NUM_REQ*C_M_CXU_DATA_W-1:0]     s_req_data0;
    logic [NUM_REQ*C_M_CXU_DATA_W-1:0]     s_req_data1;
    logic [NUM_REQ*C_M_CXU_INSN_W-1:0]     s_req_insn;
    logic [NUM_REQ*C_M_CXU_FUNC_ID_W-1:0]  s_req_func;
    logic [NUM_REQ*C_M_CXU_REQ_ID_W-1:0]   s_req_id;

    logic [NUM_REQ-1:0]                    s_resp_valid;
    logic [NUM_REQ-1:0]                    s_resp_ready;
    logic [NUM_REQ*C_M_CXU_DATA_W-1:0]     s_resp_data;
    logic [NUM_REQ*C_M_CXU_REQ_ID_W-1:0]   s_resp_id;
    logic [NUM_REQ*C_M_CXU_STATUS_W-1:0]   s_resp_status;

    logic                                  m_req_valid;
    logic                                  m_req_ready;
    logic [C_M_CXU_CXU_ID_W-1:0]           m_req_cxu;
    logic [C_M_CXU_STATE_ID_W-1:0]         m_req_state;
    logic [C_M_CXU_DATA_W-1:0]             m_req_data0;
    logic [C_M_CXU_DATA_W-1:0]             m_req_data1;
    logic [C_M_CXU_INSN_W-1:0]             m_req_insn;
    logic [C_M_CXU_FUNC_ID_W-1:0]          m_req_func;
    logic [C_M_CXU_REQ_ID_W-1:0]           m_req_id;

    logic                                  m_resp_valid;
    logic                                  m_resp_ready;
    logic [C_M_CXU_DATA_W-1:0]             m_resp_data;
    logic [C_M_CXU_REQ_ID_W-1:0]           m_resp_id;
    logic [C_M_CXU_STATUS_W-1:0]           m_resp_status;

    modport slave (
        input  s_req_valid, s_req_cxu, s_req_state, s_req_data0, s_req_data1,
               s_req_insn, s_req_func, s_req_id,
        output s_req_ready,
        output s_resp_valid, s_resp_data, s_resp_id, s_resp_status,
        input  s_resp_ready,
        output m_req_valid, m_req_cxu, m_req_state, m_req_data0, m_req_data1,
               m_req_insn, m_req_func, m_req_id,
        input  m_req_ready,
        input  m_resp_valid, m_resp_data, m_resp_id, m_resp_status,
        output m_resp_ready
    );

    modport master (
        output s_req_valid, s_req_cxu, s_req_state, s_req_data0, s_req_data1,
               s_req_insn, s_req_func, s_req_id,
        input  s_req_ready,
        input  s_resp_valid, s_resp_data, s_resp_id, s_resp_status,
        output s_resp_ready,
        input  m_req_valid, m_req_cxu, m_req_state, m_req_data0, m_req_data1,
               m_req_insn, m_req_func, m_req_id,
        output m_req_ready,
        output m_resp_valid, m_resp_data, m_resp_id, m_resp_status,
        input  m_resp_ready
    );

endinterface

// File: rtl/cx_hart_arbiter_tag_pool.sv
// Downstream tag pool: free bitmap with lowest-free priority encoder; alloc/free may share a cycle.
module cx_tag_pool #(
    parameter int unsigned NUM_TAGS = 4,
    parameter int unsigned IDX_W    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_alloc,
    input  logic [IDX_W-1:0]    i_alloc_tag,
    input  logic                i_free,
    input  logic [IDX_W-1:0]    i_free_tag,
    output logic [IDX_W-1:0]    o_lowest_free,
    output logic                o_any_free,
    output logic [NUM_TAGS-1:0] o_busy
);

    logic [NUM_TAGS-1:0] r_free;
    logic [NUM_TAGS-1:0] w_alloc_oh;
    logic [NUM_TAGS-1:0] w_free_oh;

    always_comb begin
        o_lowest_free = '0;
        o_any_free    = 1'b0;
        w_alloc_oh    = '0;
        w_free_oh     = '0;
        for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            if (!o_any_free && r_free[t]) begin
                o_any_free    = 1'b1;
                o_lowest_free = IDX_W'(t);
            end
            w_alloc_oh[t] = i_alloc && (i_alloc_tag == IDX_W'(t));
            w_free_oh[t]  = i_free  && (i_free_tag  == IDX_W'(t));
        end
    end

    // A tag freed this cycle only shows up in the encoder next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_free <= '1;
        end else begin
            r_free <= (r_free & ~w_alloc_oh) | w_free_oh;
        end
    end

    assign o_busy = ~r_free;

endmodule

// File: rtl/cx_hart_arbiter.sv
// Round-robin CX channel arbiter with tag retagging and out-of-order response routing.
// Optional per-requester stall counters: define CX_ARB_PERF_EN.
module cx_hart_arbiter
    import cxu_types::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned NUM_TAGS = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    cx_hart_arbiter_if.slave         bus,
    output logic                     o_err_spurious,
    output logic [NUM_REQ*CNT_W-1:0] o_stall_cnt
);

    localparam int unsigned GNT_W  = $clog2(NUM_REQ);
    localparam int unsigned TIDX_W = $clog2(NUM_TAGS);
    localparam int unsigned CXW    = C_M_CXU_CXU_ID_W;
    localparam int unsigned STW    = C_M_CXU_STATE_ID_W;
    localparam int unsigned DW     = C_M_CXU_DATA_W;
    localparam int unsigned INW    = C_M_CXU_INSN_W;
    localparam int unsigned FW     = C_M_CXU_FUNC_ID_W;
    localparam int unsigned IW     = C_M_CXU_REQ_ID_W;
    localparam int unsigned SW     = C_M_CXU_STATUS_W;

    cx_arb_state_e       r_state, w_state_nxt;
    logic                r_run;
    logic [GNT_W-1:0]    r_rr_ptr;
    logic [GNT_W-1:0]    r_lock_grant;
    logic [TIDX_W-1:0]   r_lock_tag;
    cx_arb_tag_entry_t   r_tab [NUM_TAGS];
    cx_arb_resp_t        r_hold [NUM_REQ];
    logic [NUM_REQ-1:0]  r_hold_valid;
    logic                r_err;

    logic                w_found;
    logic [GNT_W-1:0]    w_rr_grant;
    logic [GNT_W-1:0]    w_sel;
    logic [TIDX_W-1:0]   w_sel_tag;
    logic                w_m_req_valid;
    logic                w_req_fire;
    logic                w_lock;
    logic [NUM_REQ-1:0]  w_s_req_ready;
    logic [IW-1:0]       w_sel_id;

    logic [TIDX_W-1:0]   w_lowest_free;
    logic                w_any_free;
    logic [NUM_TAGS-1:0] w_busy;

    logic [TIDX_W-1:0]   w_rtag;
    logic                w_rtag_ok;
    logic [CX_ARB_OWNER_W-1:0] w_rowner;
    logic [IW-1:0]       w_rorig;
    logic                w_hold_full;
    logic                w_m_resp_ready;
    logic                w_resp_fire;
    logic                w_resp_acc;

    logic [NUM_REQ*DW-1:0] w_s_resp_data;
    logic [NUM_REQ*IW-1:0] w_s_resp_id;
    logic [NUM_REQ*SW-1:0] w_s_resp_status;

    cx_tag_pool #(
        .NUM_TAGS (NUM_TAGS),
        .IDX_W    (TIDX_W)
    ) u_tag_pool (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_alloc       (w_req_fire),
        .i_alloc_tag   (w_sel_tag),
        .i_free        (w_resp_acc),
        .i_free_tag    (w_rtag),
        .o_lowest_free (w_lowest_free),
        .o_any_free    (w_any_free),
        .o_busy        (w_busy)
    );

    // First pass covers requesters at/after the pointer, second pass wraps around.
    always_comb begin
        w_found    = 1'b0;
        w_rr_grant = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_found && bus.s_req_valid[j] && (GNT_W'(j) >= r_rr_ptr)) begin
                w_found    = 1'b1;
                w_rr_grant = GNT_W'(j);
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!w_found && bus.s_req_valid[j]) begin
                w_found    = 1'b1;
                w_rr_grant = GNT_W'(j);
            end
        end
    end

    // Outputs stay quiet until the first clock after reset release.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel         = w_rr_grant;
        w_sel_tag     = w_lowest_free;
        w_m_req_valid = 1'b0;
        w_req_fire    = 1'b0;
        w_lock        = 1'b0;
        w_s_req_ready = '0;
        if (r_run) begin
            unique case (r_state)
                CX_ARB_IDLE: begin
                    if (w_found && w_any_free) begin
                        w_m_req_valid = 1'b1;
                        if (bus.m_req_ready) begin
                            w_req_fire = 1'b1;
                        end else begin
                            w_lock      = 1'b1;
                            w_state_nxt = CX_ARB_LOCKED;
                        end
                    end
                end
                CX_ARB_LOCKED: begin
                    w_sel         = r_lock_grant;
                    w_sel_tag     = r_lock_tag;
                    w_m_req_valid = 1'b1;
                    if (bus.m_req_ready) begin
                        w_req_fire  = 1'b1;
                        w_state_nxt = CX_ARB_IDLE;
                    end
                end
                default: w_state_nxt = CX_ARB_IDLE;
            endcase
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            w_s_req_ready[j] = w_req_fire && (w_sel == GNT_W'(j));
        end
    end

    always_comb begin
        bus.m_req_cxu   = '0;
        bus.m_req_state = '0;
        bus.m_req_data0 = '0;
        bus.m_req_data1 = '0;
        bus.m_req_insn  = '0;
        bus.m_req_func  = '0;
        w_sel_id        = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (w_sel == GNT_W'(j)) begin
                bus.m_req_cxu   = bus.s_req_cxu[j*CXW +: CXW];
                bus.m_req_state = bus.s_req_state[j*STW +: STW];
                bus.m_req_data0 = bus.s_req_data0[j*DW +: DW];
                bus.m_req_data1 = bus.s_req_data1[j*DW +: DW];
                bus.m_req_insn  = bus.s_req_insn[j*INW +: INW];
                bus.m_req_func  = bus.s_req_func[j*FW +: FW];
                w_sel_id        = bus.s_req_id[j*IW +: IW];
            end
        end
    end

    assign bus.m_req_valid = w_m_req_valid;
    assign bus.m_req_id    = IW'(w_sel_tag);
    assign bus.s_req_ready = w_s_req_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run        <= 1'b0;
            r_state      <= CX_ARB_IDLE;
            r_rr_ptr     <= '0;
            r_lock_grant <= '0;
            r_lock_tag   <= '0;
        end else begin
            r_run   <= 1'b1;
            r_state <= w_state_nxt;
            if (w_lock) begin
                r_lock_grant <= w_rr_grant;
                r_lock_tag   <= w_lowest_free;
            end
            if (w_req_fire) begin
                r_rr_ptr <= (w_sel == GNT_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    // Table entries are only meaningful while the pool marks the tag busy.
    always_ff @(posedge i_clk) begin
        for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            if (w_req_fire && (w_sel_tag == TIDX_W'(t))) begin
                r_tab[t] <= '{owner: CX_ARB_OWNER_W'(w_sel), orig_id: w_sel_id};
            end
        end
    end

    always_comb begin
        w_rtag      = bus.m_resp_id[TIDX_W-1:0];
        w_rtag_ok   = 1'b0;
        w_rowner    = '0;
        w_rorig     = '0;
        w_hold_full = 1'b0;
        for (int unsigned t = 0; t < NUM_TAGS; t++) begin
            if ((bus.m_resp_id == IW'(t)) && w_busy[t]) begin
                w_rtag_ok = 1'b1;
                w_rowner  = r_tab[t].owner;
                w_rorig   = r_tab[t].orig_id;
            end
        end
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (w_rowner == CX_ARB_OWNER_W'(j)) begin
                w_hold_full = r_hold_valid[j];
            end
        end
        // Unallocated tags are always accepted so the switch never wedges on them.
        w_m_resp_ready = r_run && (!w_rtag_ok || !w_hold_full);
        w_resp_fire    = bus.m_resp_valid && w_m_resp_ready;
        w_resp_acc     = w_resp_fire && w_rtag_ok;
    end

    assign bus.m_resp_ready = w_m_resp_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold_valid <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_resp_fire && !w_rtag_ok) begin
                r_err <= 1'b1;
            end
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (r_hold_valid[j] && bus.s_resp_ready[j]) begin
                    r_hold_valid[j] <= 1'b0;
                end
                if (w_resp_acc && (w_rowner == CX_ARB_OWNER_W'(j))) begin
                    r_hold_valid[j] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (w_resp_acc && (w_rowner == CX_ARB_OWNER_W'(j))) begin
                r_hold[j] <= '{data: bus.m_resp_data, id: w_rorig, status: bus.m_resp_status};
            end
        end
    end

    always_comb begin
        w_s_resp_data   = '0;
        w_s_resp_id     = '0;
        w_s_resp_status = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            w_s_resp_data[j*DW +: DW]   = r_hold[j].data;
            w_s_resp_id[j*IW +: IW]     = r_hold[j].id;
            w_s_resp_status[j*SW +: SW] = r_hold[j].status;
        end
    end

    assign bus.s_resp_valid  = r_hold_valid;
    assign bus.s_resp_data   = w_s_resp_data;
    assign bus.s_resp_id     = w_s_resp_id;
    assign bus.s_resp_status = w_s_resp_status;
    assign o_err_spurious    = r_err;

`ifdef CX_ARB_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt [NUM_REQ];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                r_stall_cnt[j] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (bus.s_req_valid[j] && !w_s_req_ready[j] && (r_stall_cnt[j] != '1)) begin
                    r_stall_cnt[j] <= r_stall_cnt[j] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_stall_cnt = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            o_stall_cnt[j*CNT_W +: CNT_W] = r_stall_cnt[j];
        end
    end
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cx_hart_arbiter.sv
// Directed bench for cx_hart_arbiter (NUM_REQ=2, NUM_TAGS=4); stall counters checked if CX_ARB_PERF_EN.
`timescale 1ns/1ps
module tb_cx_hart_arbiter;
    import cxu_types::*;

    localparam int unsigned NR = 2;
    localparam int unsigned NT = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned DW = C_M_CXU_DATA_W;
    localparam int unsigned IW = C_M_CXU_REQ_ID_W;
    localparam int unsigned SW = C_M_CXU_STATUS_W;
`ifdef CX_ARB_PERF_EN
    localparam logic [63:0] EXP_STALL = 64'd4;
`else
    localparam logic [63:0] EXP_STALL = 64'd0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_spur;
    logic [NR*CW-1:0] stall_cnt;
    int n_cmp = 0;
    int n_bad = 0;

    cx_hart_arbiter_if #(.NUM_REQ(NR)) bus ();

    cx_hart_arbiter #(
        .NUM_REQ  (NR),
        .NUM_TAGS (NT),
        .CNT_W    (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus),
        .o_err_spurious (err_spur),
        .o_stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.s_req_valid   = '0;
        bus.s_req_cxu     = {4'h2, 4'h1};
        bus.s_req_state   = '0;
        bus.s_req_data0   = {32'h0000_00A1, 32'h0000_00A0};
        bus.s_req_data1   = {32'h0000_00B1, 32'h0000_00B0};
        bus.s_req_insn    = {32'h0000_0101, 32'h0000_0100};
        bus.s_req_func    = {10'h004, 10'h003};
        bus.s_req_id      = '0;
        bus.s_resp_ready  = '1;
        bus.m_req_ready   = 1'b0;
        bus.m_resp_valid  = 1'b0;
        bus.m_resp_id     = '0;
        bus.m_resp_data   = '0;
        bus.m_resp_status = '0;
    endtask

    task automatic set_ids(input logic [IW-1:0] id0, input logic [IW-1:0] id1);
        bus.s_req_id = {id1, id0};
    endtask

    task automatic send_resp(input logic [IW-1:0] tag, input logic [DW-1:0] data, input logic [SW-1:0] st);
        bus.m_resp_valid  = 1'b1;
        bus.m_resp_id     = tag;
        bus.m_resp_data   = data;
        bus.m_resp_status = st;
    endtask

    // Ends on a falling edge with the first post-release rising edge already taken.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        drive_idle();
        bus.s_req_valid = 2'b01;
        // ---- 1: reset
        @(negedge clk); #1;
        check_eq("rst_m_req_valid", bus.m_req_valid, 0);
        check_eq("rst_s_req_ready", bus.s_req_ready, 0);
        check_eq("rst_m_resp_ready", bus.m_resp_ready, 0);
        check_eq("rst_s_resp_valid", bus.s_resp_valid, 0);
        check_eq("rst_err", err_spur, 0);
        check_eq("rst_stall", stall_cnt, 0);
        bus.s_req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        set_ids(6'h11, 6'h22);
        bus.s_req_valid = 2'b01; bus.m_req_ready = 1'b1; #1;
        check_eq("t1_first_gnt", bus.s_req_ready, 2'b01);
        check_eq("t1_first_tag", bus.m_req_id, 0);
        @(negedge clk);
        bus.m_req_ready = 1'b0; #1;
        check_eq("t1_lock_valid", bus.m_req_valid, 1);
        check_eq("t1_lock_tag", bus.m_req_id, 1);
        @(negedge clk); #1;
        check_eq("t1_locked_tag", bus.m_req_id, 1);
        rst_n = 1'b0; #1;
        check_eq("t1_midrst_m_valid", bus.m_req_valid, 0);
        check_eq("t1_midrst_s_ready", bus.s_req_ready, 0);
        check_eq("t1_midrst_s_resp_valid", bus.s_resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1; bus.s_req_valid = '0;
        @(negedge clk); #1;
        check_eq("t1_err_after_rst", err_spur, 0);
        send_resp(6'd0, 32'h1234, 2'd0); #1;
        check_eq("t1_stale_resp_ready", bus.m_resp_ready, 1);
        @(negedge clk);
        bus.m_resp_valid = 1'b0; #1;
        check_eq("t1_stale_err", err_spur, 1);
        check_eq("t1_stale_dropped", bus.s_resp_valid, 0);
        bus.s_req_valid = 2'b11; bus.m_req_ready = 1'b1; #1;
        check_eq("t1_ptr_reset_gnt", bus.s_req_ready, 2'b01);
        check_eq("t1_tags_free", bus.m_req_id, 0);
        @(negedge clk);

        // ---- 2: contention
        do_reset();
        set_ids(6'h11, 6'h22);
        bus.s_req_valid = 2'b11; bus.m_req_ready = 1'b1;
        begin
            logic [1:0]  exp_gnt [4];
            logic [31:0] exp_d0  [4];
            exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
            exp_d0  = '{32'hA0, 32'hA1, 32'hA0, 32'hA1};
            for (int k = 0; k < 4; k++) begin
                #1;
                check_eq($sformatf("t2_gnt%0d", k), bus.s_req_ready, exp_gnt[k]);
                check_eq($sformatf("t2_tag%0d", k), bus.m_req_id, k);
                check_eq($sformatf("t2_data0_%0d", k), bus.m_req_data0, exp_d0[k]);
                @(negedge clk);
            end
        end
        #1;
        check_eq("t2_notag_valid", bus.m_req_valid, 0);
        check_eq("t2_notag_ready", bus.s_req_ready, 0);
        @(negedge clk);
        send_resp(6'd2, 32'hD0D0_0002, 2'd1); #1;
        check_eq("t2_resp_ready", bus.m_resp_ready, 1);
        check_eq("t2_free_same_cycle", bus.m_req_valid, 0);
        @(negedge clk);
        bus.m_resp_valid = 1'b0; #1;
        check_eq("t2_realloc_valid", bus.m_req_valid, 1);
        check_eq("t2_realloc_tag", bus.m_req_id, 2);
        check_eq("t2_realloc_gnt", bus.s_req_ready, 2'b01);
        check_eq("t2_resp_valid", bus.s_resp_valid, 2'b01);
        check_eq("t2_resp_id0", bus.s_resp_id[0 +: IW], 6'h11);
        check_eq("t2_resp_data0", bus.s_resp_data[0 +: DW], 32'hD0D0_0002);
        check_eq("t2_resp_st0", bus.s_resp_status[0 +: SW], 1);
        @(negedge clk);
        bus.s_req_valid = '0; #1;
        check_eq("t2_resp_popped", bus.s_resp_valid, 0);
        @(negedge clk);

        // ---- 3: back-pressure
        do_reset();
        set_ids(6'h05, 6'h09);
        bus.s_req_valid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) bus.s_req_valid = 2'b11;
            #1;
            check_eq($sformatf("t3_hold_valid%0d", c), bus.m_req_valid, 1);
            check_eq($sformatf("t3_hold_tag%0d", c), bus.m_req_id, 0);
            check_eq($sformatf("t3_hold_data0_%0d", c), bus.m_req_data0, 32'hA0);
            check_eq($sformatf("t3_hold_noready%0d", c), bus.s_req_ready, 0);
            @(negedge clk);
        end
        bus.m_req_ready = 1'b1; #1;
        check_eq("t3_release_gnt", bus.s_req_ready, 2'b01);
        check_eq("t3_release_tag", bus.m_req_id, 0);
        check_eq("t3_release_insn", bus.m_req_insn, 32'h100);
        @(negedge clk); #1;
        check_eq("t3_next_gnt", bus.s_req_ready, 2'b10);
        check_eq("t3_next_tag", bus.m_req_id, 1);
        check_eq("t3_next_data0", bus.m_req_data0, 32'hA1);
        @(negedge clk);

        // ---- 4: out-of-order responses
        do_reset();
        set_ids(6'h05, 6'h09);
        bus.m_req_ready = 1'b1; bus.s_req_valid = 2'b01; #1;
        check_eq("t4_tag_r0", bus.m_req_id, 0);
        @(negedge clk);
        bus.s_req_valid = 2'b10; #1;
        check_eq("t4_gnt_r1", bus.s_req_ready, 2'b10);
        check_eq("t4_tag_r1", bus.m_req_id, 1);
        @(negedge clk);
        bus.s_req_valid = '0;
        send_resp(6'd1, 32'h1111, 2'd2); #1;
        check_eq("t4_resp1_ready", bus.m_resp_ready, 1);
        check_eq("t4_latency", bus.s_resp_valid, 0);
        @(negedge clk);
        send_resp(6'd0, 32'h2222, 2'd3); #1;
        check_eq("t4_r1_valid", bus.s_resp_valid, 2'b10);
        check_eq("t4_r1_id", bus.s_resp_id[IW +: IW], 6'h09);
        check_eq("t4_r1_data", bus.s_resp_data[DW +: DW], 32'h1111);
        check_eq("t4_r1_status", bus.s_resp_status[SW +: SW], 2);
        @(negedge clk);
        bus.m_resp_valid = 1'b0; #1;
        check_eq("t4_r0_valid", bus.s_resp_valid, 2'b01);
        check_eq("t4_r0_id", bus.s_resp_id[0 +: IW], 6'h05);
        check_eq("t4_r0_data", bus.s_resp_data[0 +: DW], 32'h2222);
        check_eq("t4_r0_status", bus.s_resp_status[0 +: SW], 3);
        @(negedge clk);

        // ---- 5: response hold full
        do_reset();
        set_ids(6'h03, 6'h07);
        bus.s_resp_ready = 2'b00; bus.m_req_ready = 1'b1;
        bus.s_req_valid = 2'b01; #1;
        check_eq("t5_tag0", bus.m_req_id, 0);
        @(negedge clk); #1;
        check_eq("t5_wrap_gnt", bus.s_req_ready, 2'b01);
        check_eq("t5_tag1", bus.m_req_id, 1);
        @(negedge clk);
        bus.s_req_valid = 2'b10; #1;
        check_eq("t5_tag2", bus.m_req_id, 2);
        @(negedge clk);
        bus.s_req_valid = '0;
        send_resp(6'd0, 32'hAAAA, 2'd0); #1;
        check_eq("t5_first_ready", bus.m_resp_ready, 1);
        @(negedge clk);
        send_resp(6'd1, 32'hBBBB, 2'd0); #1;
        check_eq("t5_full_blocks", bus.m_resp_ready, 0);
        check_eq("t5_hold0", bus.s_resp_valid, 2'b01);
        @(negedge clk);
        send_resp(6'd2, 32'hCCCC, 2'd1); #1;
        check_eq("t5_other_owner", bus.m_resp_ready, 1);
        @(negedge clk);
        bus.m_resp_valid = 1'b0; bus.s_resp_ready = 2'b01; #1;
        check_eq("t5_both_held", bus.s_resp_valid, 2'b11);
        check_eq("t5_r1_id", bus.s_resp_id[IW +: IW], 6'h07);
        check_eq("t5_r0_data", bus.s_resp_data[0 +: DW], 32'hAAAA);
        @(negedge clk);
        send_resp(6'd1, 32'hBBBB, 2'd0); #1;
        check_eq("t5_after_pop_ready", bus.m_resp_ready, 1);
        check_eq("t5_after_pop_valid", bus.s_resp_valid, 2'b10);
        @(negedge clk);
        bus.m_resp_valid = 1'b0; #1;
        check_eq("t5_refill_valid", bus.s_resp_valid, 2'b11);
        check_eq("t5_refill_data", bus.s_resp_data[0 +: DW], 32'hBBBB);
        check_eq("t5_refill_id", bus.s_resp_id[0 +: IW], 6'h03);
        bus.s_resp_ready = 2'b11;
        @(negedge clk);

        // ---- 6: spurious response and stall counters
        do_reset();
        send_resp(6'd3, 32'hDEAD, 2'd0); #1;
        check_eq("t6_spur_ready", bus.m_resp_ready, 1);
        check_eq("t6_err_before", err_spur, 0);
        @(negedge clk);
        bus.m_resp_valid = 1'b0; #1;
        check_eq("t6_err_set", err_spur, 1);
        check_eq("t6_dropped", bus.s_resp_valid, 0);
        bus.s_req_valid = 2'b01; bus.m_req_ready = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_eq("t6_stall0", stall_cnt[0 +: CW], EXP_STALL);
        check_eq("t6_stall1", stall_cnt[CW +: CW], 0);
        check_eq("t6_err_sticky", err_spur, 1);
        bus.s_req_valid = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
